seq_slice_adder: RTL and testbench



---
 rtl/seq_slice_adder_pkg.sv | 19 +
 rtl/seq_slice_adder_slice_adder.sv | 14 +
 rtl/seq_slice_adder.sv | 120 ++++++++++++
 tb/tb_seq_slice_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_slice_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder.
package seq_slice_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned calc_nslice(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register width; a single-slice build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/seq_slice_adder_slice_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module slice_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             c_i,
  output logic [CHUNK-1:0] s,
  output logic             c_o
);

  assign {c_o, s} = (CHUNK+1)'(a_s) + (CHUNK+1)'(b_s) + (CHUNK+1)'(c_i);

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder: sums CHUNK bits per clock through a registered carry.
// Optional ADDSUB_EN macro adds a 'sub' port selecting a - b.
module seq_slice_adder
  import seq_slice_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NSLICE = calc_nslice(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] s;
  logic             c_o;

  // Subtraction is folded into the latched operand: a + ~b + 1.
  always_comb begin
    b_d     = b;
    carry_d = cin;
`ifdef ADDSUB_EN
    if (sub) begin
      b_d     = ~b;
      carry_d = 1'b1;
    end
`endif
  end

  assign a_s = a_q[idx_q * CHUNK +: CHUNK];
  assign b_s = b_q[idx_q * CHUNK +: CHUNK];

  slice_adder #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a_s(a_s),
    .b_s(b_s),
    .c_i(carry_q),
    .s  (s),
    .c_o(c_o)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      // Covers both IDLE and the consume-and-reload cycle in DONE.
      a_q         <= a;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          sum_q[idx_q * CHUNK +: CHUNK] <= s;
          carry_q                       <= c_o;
          idx_q                         <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout_q      <= c_o;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Scoreboard bench for seq_slice_adder: 32/4 and 8/8 instances; ADDSUB_EN cases when defined.
module tb_seq_slice_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1, cout;
  logic [31:0] a = '0, b = '0, sum;
  logic        in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, out_valid2, out_ready2 = 1'b1, cout2;
  logic [7:0]  a2 = '0, b2 = '0, sum2;
`ifdef ADDSUB_EN
  logic        sub_r = 1'b0;
  logic        sub2  = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp2_q[$];
  int          acc_q[$];
  int          acc2_q[$];
  logic        ov_prev = 1'b0, ov2_prev = 1'b0;

  seq_slice_adder #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
    .sub(sub_r),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  seq_slice_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2),
`ifdef ADDSUB_EN
    .sub(sub2),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected handshake", name);
  endtask

  // Monitor for the 32/4 instance: latency on rise, value on handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (acc_q.size() == 0) timeout("unexpected_valid");
      else chk("latency32", 33'(cyc - acc_q.pop_front()), 33'd8);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) timeout("unexpected_result");
      else chk("result32", {cout, sum}, exp_q.pop_front());
    end
    ov_prev = out_valid;
  end

  always @(negedge clk) begin
    if (out_valid2 && !ov2_prev) begin
      if (acc2_q.size() == 0) timeout("unexpected_valid8");
      else chk("latency8", 33'(cyc - acc2_q.pop_front()), 33'd1);
    end
    if (out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) timeout("unexpected_result8");
      else chk("result8", 33'({cout2, sum2}), exp2_q.pop_front());
    end
    ov2_prev = out_valid2;
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int unsigned d, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic [32:0] ev);
    int unsigned n = 0;
    if (d == 0) begin a = av; b = bv; cin = cv; in_valid = 1'b1; end
    else begin a2 = av[7:0]; b2 = bv[7:0]; cin2 = cv; in_valid2 = 1'b1; end
    @(negedge clk);
    while (!((d == 0) ? in_ready : in_ready2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!((d == 0) ? in_ready : in_ready2)) begin
      timeout("accept");
      in_valid = 1'b0;
      in_valid2 = 1'b0;
      return;
    end
    if (d == 0) exp_q.push_back(ev); else exp2_q.push_back(ev);
    @(posedge clk);
    #1;
    if (d == 0) begin in_valid = 1'b0; acc_q.push_back(cyc); end
    else begin in_valid2 = 1'b0; acc2_q.push_back(cyc); end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("wait_valid");
  endtask

  initial begin
    #12;
    chk("rst_sum", 33'(sum), 33'h0);
    chk("rst_cout", 33'(cout), 33'h0);
    chk("rst_out_valid", 33'(out_valid), 33'h0);
    chk("rst_in_ready", 33'(in_ready), 33'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(0, 32'h00000001, 32'h00000002, 1'b0, {1'b0, 32'h00000003});
    send(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, {1'b1, 32'h00000000});
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF});
    send(0, 32'h89ABCDEF, 32'h76543210, 1'b1, {1'b1, 32'h00000000});
    send(0, 32'h0F0F0F0F, 32'h01010101, 1'b0, {1'b0, 32'h10101010});
    drain();

    // Backpressure: result held, new operands refused until out_ready.
    out_ready = 1'b0;
    send(0, 32'hDEADBEEF, 32'h01234567, 1'b0, {1'b0, 32'hDFD10456});
    wait_valid();
    @(posedge clk);
    #1;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 33'(in_ready), 33'h0);
      chk("hold_out_valid", 33'(out_valid), 33'h1);
      chk("hold_value", {cout, sum}, {1'b0, 32'hDFD10456});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(0, 32'h12345678, 32'h11111111, 1'b0, {1'b0, 32'h23456789});
    drain();

    // Asynchronous reset in the middle of RUN (idx=3).
    send(0, 32'h00000FFF, 32'h00000111, 1'b0, {1'b0, 32'h00001110});
    repeat (3) @(posedge clk);
    #1;
    chk("partial_sum", 33'(sum[11:0]), 33'h110);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("abort_sum", 33'(sum), 33'h0);
    chk("abort_cout", 33'(cout), 33'h0);
    chk("abort_out_valid", 33'(out_valid), 33'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 33'(in_ready), 33'h1);
    @(posedge clk);
    #1;
    send(0, 32'h0000000A, 32'h00000005, 1'b0, {1'b0, 32'h0000000F});

    // Single-slice instance.
    send(1, 32'hF0, 32'h20, 1'b1, 33'h111);
    send(1, 32'h7F, 32'h01, 1'b0, 33'h080);
    drain();

`ifdef ADDSUB_EN
    sub_r = 1'b1;
    send(0, 32'd5, 32'd7, 1'b0, {1'b0, 32'hFFFFFFFE});
    send(0, 32'd7, 32'd5, 1'b1, {1'b1, 32'h00000002});
    sub_r = 1'b0;
    send(0, 32'd7, 32'd5, 1'b0, {1'b0, 32'h0000000C});
    drain();
`endif

    chk("queue_empty", 33'(exp_q.size() + exp2_q.size()), 33'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
